nested_loop_counter: RTL and testbench

- Parametrised multi-dimensional loop counter: generalises the single wrap-at-target counter to NUM_DIMS nested loops.
- Each loop level has a runtime bound and stride. Bounds and strides are latched when a run starts.
- The index tuple is emitted as a valid/ready stream; the stream stalls under back-pressure.
- Drives window/pixel/channel address generation in front of the streaming convolution datapath.

---
 rtl/nested_loop_counter_pkg.sv | 10 +
 rtl/loop_counter_stage.sv | 40 ++++
 rtl/nested_loop_counter.sv | 105 ++++++++++
 tb/tb_nested_loop_counter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/nested_loop_counter_pkg.sv
// Shared types and defaults for the nested loop counter: FSM states and index vector.
package nested_loop_counter_pkg;
  localparam int CNT_W_DEF    = 16;
  localparam int NUM_DIMS_DEF = 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef logic [CNT_W_DEF-1:0] cnt_t;
  typedef cnt_t [NUM_DIMS_DEF-1:0] idx_vec_t;
endpackage

// File: rtl/loop_counter_stage.sv
// One loop level: index register with stride advance, wrap at bound and carry out.
module loop_counter_stage
  import nested_loop_counter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc_en,
  input  logic             carry_in,
  input  logic [CNT_W-1:0] stride,
  input  logic [CNT_W-1:0] bound,
  output logic [CNT_W-1:0] idx,
  output logic             first,
  output logic             last,
  output logic             carry_out
);

  logic [CNT_W-1:0] step;
  logic [CNT_W:0]   sum;

  // One extra bit keeps idx+stride from wrapping back below the bound.
  assign step      = (stride == '0) ? CNT_W'(1) : stride;
  assign sum       = {1'b0, idx} + {1'b0, step};
  assign last      = (sum >= {1'b0, bound});
  assign first     = (idx == '0);
  assign carry_out = carry_in & last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (inc_en && carry_in) begin
      idx <= last ? '0 : sum[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/nested_loop_counter.sv
// Odometer-style multi-dimensional loop counter emitting index tuples on a valid/ready stream.
module nested_loop_counter
  import nested_loop_counter_pkg::*;
#(
  parameter int NUM_DIMS = NUM_DIMS_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           clear,
  input  logic [NUM_DIMS-1:0][CNT_W-1:0] bound,
  input  logic [NUM_DIMS-1:0][CNT_W-1:0] stride,
  output logic [NUM_DIMS-1:0][CNT_W-1:0] idx,
  output logic                           idx_valid,
  input  logic                           idx_ready,
  output logic [NUM_DIMS-1:0]            first,
  output logic [NUM_DIMS-1:0]            last,
  output logic                           busy,
  output logic                           done
);

  state_t                        state;
  logic [NUM_DIMS-1:0][CNT_W-1:0] bound_q;
  logic [NUM_DIMS-1:0][CNT_W-1:0] stride_q;
  logic                          done_q;
  logic [NUM_DIMS:0]             carry;
  logic [NUM_DIMS-1:0]           first_raw;
  logic [NUM_DIMS-1:0]           last_raw;
  logic                          fire;
  logic                          all_last;
  logic                          advance;
  logic                          stage_clear;
  logic                          any_zero;

  assign fire        = (state == RUN) && idx_ready;
  assign carry[0]    = 1'b1;
  assign all_last    = carry[NUM_DIMS];
  // The final fire holds the last tuple on idx through DONE instead of wrapping.
  assign advance     = fire && !all_last && !clear;
  assign stage_clear = clear || (state == DONE);

  always_comb begin
    any_zero = 1'b0;
    for (int d = 0; d < NUM_DIMS; d++) begin
      if (bound[d] == '0) any_zero = 1'b1;
    end
  end

  for (genvar d = 0; d < NUM_DIMS; d++) begin : g_stage
    loop_counter_stage #(.CNT_W(CNT_W)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .clear     (stage_clear),
      .inc_en    (advance),
      .carry_in  (carry[d]),
      .stride    (stride_q[d]),
      .bound     (bound_q[d]),
      .idx       (idx[d]),
      .first     (first_raw[d]),
      .last      (last_raw[d]),
      .carry_out (carry[d+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      done_q   <= 1'b0;
      bound_q  <= '0;
      stride_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              bound_q  <= bound;
              stride_q <= stride;
              if (any_zero) done_q <= 1'b1;
              else          state  <= RUN;
            end
          end
          RUN: begin
            if (fire && all_last) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign idx_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = done_q;
  assign first     = idx_valid ? first_raw : '0;
  assign last      = idx_valid ? last_raw  : '0;

endmodule

// File: tb/tb_nested_loop_counter.sv
// Scoreboard bench for nested_loop_counter: stimulus pushes expected tuples, a monitor pops on every fire.
module tb_nested_loop_counter;
  localparam int ND = 3;
  localparam int W  = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic                   clear = 1'b0;
  logic [ND-1:0][W-1:0]   bound = '0;
  logic [ND-1:0][W-1:0]   stride = '0;
  logic [ND-1:0][W-1:0]   idx;
  logic                   idx_valid;
  logic                   idx_ready = 1'b1;
  logic [ND-1:0]          first;
  logic [ND-1:0]          last;
  logic                   busy;
  logic                   done;

  nested_loop_counter #(.NUM_DIMS(ND), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .bound(bound), .stride(stride), .idx(idx), .idx_valid(idx_valid),
    .idx_ready(idx_ready), .first(first), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [53:0] vec;
    bit          fin;
  } exp_t;

  exp_t                 q[$];
  int                   n_tests = 0;
  int                   n_fail  = 0;
  int                   popped  = 0;
  int                   busy_cyc = 0;
  bit                   pend_done = 0;
  bit                   allow_done = 0;
  bit                   stalled = 0;
  logic [ND-1:0][W-1:0] prev_idx;
  bit                   pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model(input int b2, b1, b0, s2, s1, s0);
    int e2, e1, e0;
    exp_t e;
    e2 = (s2 == 0) ? 1 : s2;
    e1 = (s1 == 0) ? 1 : s1;
    e0 = (s0 == 0) ? 1 : s0;
    for (int a2 = 0; a2 < b2; a2 += e2)
      for (int a1 = 0; a1 < b1; a1 += e1)
        for (int a0 = 0; a0 < b0; a0 += e0) begin
          logic [2:0] f, l;
          f = {a2 == 0, a1 == 0, a0 == 0};
          l = {a2 + e2 >= b2, a1 + e1 >= b1, a0 + e0 >= b0};
          e.vec = {W'(a2), W'(a1), W'(a0), f, l};
          e.fin = &l;
          q.push_back(e);
        end
  endtask

  // Monitor: checks each accepted tuple, stall stability and done timing.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cyc++;
      if (stalled && idx_valid) check("stall_hold", idx, prev_idx);
      stalled  = idx_valid && !idx_ready && !clear;
      prev_idx = idx;
      if (pend_done) begin
        check("done_pulse", done, 1);
        pend_done = 0;
      end else if (done && !allow_done) begin
        check("unexpected_done", done, 0);
      end
      if (idx_valid && idx_ready && !clear) begin
        if (q.size() == 0) begin
          check("extra_tuple", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("tuple", {idx, first, last}, e.vec);
          popped++;
          if (e.fin) pend_done = 1;
        end
      end
    end else begin
      stalled   = 0;
      pend_done = 0;
    end
  end

  task automatic run(input int b2, b1, b0, s2, s1, s0, input bit toggle, input bit scramble);
    push_model(b2, b1, b0, s2, s1, s0);
    bound     = {W'(b2), W'(b1), W'(b0)};
    stride    = {W'(s2), W'(s1), W'(s0)};
    idx_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("first_valid_latency", {idx_valid, idx}, {1'b1, 48'h0});
    if (scramble) begin
      bound  = {W'(1), W'(1), W'(1)};
      stride = {W'(7), W'(7), W'(7)};
    end
    for (int c = 0; c < 300; c++) begin
      idx_ready = toggle ? pat[c % 4] : 1'b1;
      tick();
      if (q.size() == 0 && !busy) break;
    end
    idx_ready = 1'b1;
    check("drain_remaining", q.size(), 0);
    tick();
    tick();
    check("idle_after_run", {busy, idx_valid, done, idx}, 0);
  endtask

  initial begin
    #2;
    check("reset_outputs", {idx_valid, busy, done, first, last, idx}, 0);
    tick();
    rst = 1'b0;
    tick();

    popped = 0; busy_cyc = 0;
    run(1, 2, 3, 1, 1, 1, 0, 0);
    check("t1_count", popped, 6);
    check("t1_busy_cycles", busy_cyc, 6);

    popped = 0;
    run(1, 2, 3, 1, 1, 1, 1, 1);
    check("t2_count_backpressure", popped, 6);

    popped = 0;
    run(1, 1, 5, 1, 1, 2, 0, 0);
    check("t3_stride2_count", popped, 3);

    popped = 0;
    run(1, 1, 5, 0, 0, 0, 0, 0);
    check("t3_stride0_count", popped, 5);

    allow_done = 1;
    bound = {W'(3), W'(0), W'(2)};
    stride = {W'(1), W'(1), W'(1)};
    start = 1'b1;
    tick();
    start = 1'b0;
    check("empty_done", {done, idx_valid, busy}, 3'b100);
    tick();
    check("empty_done_end", {done, idx_valid, busy}, 3'b000);
    allow_done = 0;
    tick();

    popped = 0;
    push_model(1, 2, 3, 1, 1, 1);
    bound = {W'(1), W'(2), W'(3)};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 50 && popped < 2; c++) tick();
    check("clear_at_third", idx, {W'(0), W'(0), W'(2)});
    clear = 1'b1; start = 1'b1; idx_ready = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    q.delete();
    check("clear_result", {idx_valid, busy, done, idx}, 0);
    tick();
    check("clear_no_done", {done, idx_valid}, 0);
    popped = 0;
    run(1, 2, 3, 1, 1, 1, 0, 0);
    check("restart_count", popped, 6);

    push_model(2, 2, 2, 1, 1, 1);
    bound = {W'(2), W'(2), W'(2)};
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", {idx_valid, busy, done, idx}, 0);
    q.delete();
    tick();
    rst = 1'b0;
    tick();
    popped = 0;
    run(2, 1, 4, 1, 1, 3, 0, 0);
    check("post_rst_count", popped, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
